// File: rtl/wrapctr_pkg.sv
// wrapctr_pkg: shared types and defaults for the wrap-around ticket scheduler
package wrapctr_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RECONF} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 10;
  localparam int DEF_RESET_LIMIT = 500;
  localparam int WRAP_CNT_W = 16;
endpackage

// File: rtl/wrapctr_sched_if.sv
// wrapctr_sched_if: request/grant and limit-config bus between clients and the scheduler
interface wrapctr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 10
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0] ticket;
  logic cfg_valid;
  logic [WIDTH-1:0] cfg_limit;
  logic cfg_ready;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic wrap;
  modport master (output req, cfg_valid, cfg_limit, input gnt, ticket, cfg_ready, limit, count, wrap);
  modport slave (input req, cfg_valid, cfg_limit, output gnt, ticket, cfg_ready, limit, count, wrap);
endinterface

// File: rtl/wrapctr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [IW-1:0] j;
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
        win[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wrapctr_sched.sv
// wrapctr_sched: round-robin ticket scheduler owning a 1..limit wrap counter and its limit.
// Optional wrap_count output enabled by WRAPCTR_SCHED_WRAP_CNT_EN.
module wrapctr_sched
  import wrapctr_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int RESET_LIMIT = DEF_RESET_LIMIT
) (
  input logic clk,
  input logic rst,
  wrapctr_sched_if.slave bus
`ifdef WRAPCTR_SCHED_WRAP_CNT_EN
  , output logic [WRAP_CNT_W-1:0] wrap_count
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, limit_q, limit_d, pend_q, pend_d, ticket_q, ticket_d, nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, win;
  logic [IW-1:0] ptr_q, ptr_d, idx;
  logic wrap_q, wrap_d, any, accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (.req(bus.req), .ptr(ptr_q), .win(win), .idx(idx), .any(any));

  assign accept = bus.cfg_valid && state_q != RECONF;
  assign nxt = count_q == limit_q ? WIDTH'(1) : count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    pend_d = pend_q;
    ptr_d = ptr_q;
    gnt_d = '0;
    ticket_d = ticket_q;
    wrap_d = 1'b0;
    if (state_q == RECONF) begin
      limit_d = pend_q;
      count_d = count_q > pend_q ? '0 : count_q;
      state_d = IDLE;
    end else if (accept) begin
      pend_d = bus.cfg_limit == '0 ? WIDTH'(1) : bus.cfg_limit;
      state_d = RECONF;
    end else if (any) begin
      count_d = nxt;
      ticket_d = nxt;
      wrap_d = count_q == limit_q;
      gnt_d = win;
      ptr_d = idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
      state_d = GRANT;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= WIDTH'(RESET_LIMIT);
      pend_q <= WIDTH'(RESET_LIMIT);
      ptr_q <= '0;
      gnt_q <= '0;
      ticket_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      ticket_q <= ticket_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef WRAPCTR_SCHED_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wcnt_q, wcnt_d;
  always_comb wcnt_d = accept ? '0 : (wrap_d && ~&wcnt_q) ? wcnt_q + 1'b1 : wcnt_q;
  always_ff @(posedge clk) begin
    if (rst) wcnt_q <= '0;
    else wcnt_q <= wcnt_d;
  end
  assign wrap_count = wcnt_q;
`endif

  assign bus.gnt = gnt_q;
  assign bus.ticket = ticket_q;
  assign bus.wrap = wrap_q;
  assign bus.count = count_q;
  assign bus.limit = limit_q;
  assign bus.cfg_ready = state_q != RECONF;
endmodule
